// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush control for the five-stage pipeline.
// Load-use, taken-branch and multi-cycle data-memory handshake sequencing. Rev 1.0
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_addr_i,
  input  logic [4:0]       id_rt_addr_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_mem_read_i,
  input  logic [4:0]       ex_rt_addr_i,
  input  logic             id_branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             mem_start_o,
  output logic             pc_write_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_stall_o,
  output logic             idex_flush_o,
  output logic             exmem_stall_o,
  output logic             memwb_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             mem_err_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic            mem_stall;
  logic            load_use;
  logic [TW-1:0]   tmo_cnt;

  assign load_use = ex_mem_read_i && (ex_rt_addr_i != 5'd0) &&
                    ((ex_rt_addr_i == id_rs_addr_i) ||
                     (id_uses_rt_i && (ex_rt_addr_i == id_rt_addr_i)));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= RUN;
    else        state <= state_nxt;
  end

  // Outputs are forced idle while reset is held, even if mem_req_i is high.
  always_comb begin
    state_nxt      = state;
    mem_stall      = 1'b0;
    mem_start_o    = 1'b0;
    pc_write_o     = 1'b1;
    ifid_stall_o   = 1'b0;
    ifid_flush_o   = 1'b0;
    idex_stall_o   = 1'b0;
    idex_flush_o   = 1'b0;
    exmem_stall_o  = 1'b0;
    memwb_bubble_o = 1'b0;
    if (rst_i) begin
      case (state)
        RUN: begin
          if (mem_req_i) begin
            mem_start_o = 1'b1;
            mem_stall   = 1'b1;
            state_nxt   = MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_ack_i) state_nxt = RUN;
          else           mem_stall = 1'b1;
        end
        default: state_nxt = RUN;
      endcase

      if (mem_stall) begin
        pc_write_o     = 1'b0;
        ifid_stall_o   = 1'b1;
        idex_stall_o   = 1'b1;
        exmem_stall_o  = 1'b1;
        memwb_bubble_o = 1'b1;
      end else if (load_use) begin
        pc_write_o   = 1'b0;
        ifid_stall_o = 1'b1;
        idex_flush_o = 1'b1;
      end else if (id_branch_taken_i) begin
        ifid_flush_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (!pc_write_o && (stall_cnt_o != {CNT_W{1'b1}}))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (ifid_flush_o && (flush_cnt_o != {CNT_W{1'b1}}))
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

  // The wait continues past the timeout; the error flag only records it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tmo_cnt   <= '0;
      mem_err_o <= 1'b0;
    end else if (state == RUN) begin
      if (mem_req_i) tmo_cnt <= '0;
    end else begin
      if (tmo_cnt != TW'(TIMEOUT)) tmo_cnt <= tmo_cnt + TW'(1);
      if (tmo_cnt == TW'(TIMEOUT - 1)) mem_err_o <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench for pipeline_hazard_ctrl.
// Rev 1.0
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 16;

  // {mem_start, pc_write, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_bubble}
  localparam logic [7:0] C_IDLE   = 8'b0100_0000;
  localparam logic [7:0] C_MSTART = 8'b1010_1011;
  localparam logic [7:0] C_MSTALL = 8'b0010_1011;
  localparam logic [7:0] C_LDUSE  = 8'b0010_0100;
  localparam logic [7:0] C_BRANCH = 8'b0101_0000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             id_uses_rt, ex_mem_read, br_taken, mem_req, mem_ack;
  logic             mem_start, pc_write, ifid_stall, ifid_flush;
  logic             idex_stall, idex_flush, exmem_stall, memwb_bubble;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             mem_err;
  logic [7:0]       ctrl;

  int n_tests = 0;
  int n_fail  = 0;

  assign ctrl = {mem_start, pc_write, ifid_stall, ifid_flush,
                 idex_stall, idex_flush, exmem_stall, memwb_bubble};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .id_rs_addr_i     (id_rs),
    .id_rt_addr_i     (id_rt),
    .id_uses_rt_i     (id_uses_rt),
    .ex_mem_read_i    (ex_mem_read),
    .ex_rt_addr_i     (ex_rt),
    .id_branch_taken_i(br_taken),
    .mem_req_i        (mem_req),
    .mem_ack_i        (mem_ack),
    .mem_start_o      (mem_start),
    .pc_write_o       (pc_write),
    .ifid_stall_o     (ifid_stall),
    .ifid_flush_o     (ifid_flush),
    .idex_stall_o     (idex_stall),
    .idex_flush_o     (idex_flush),
    .exmem_stall_o    (exmem_stall),
    .memwb_bubble_o   (memwb_bubble),
    .stall_cnt_o      (stall_cnt),
    .flush_cnt_o      (flush_cnt),
    .mem_err_o        (mem_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge, then let combinational outputs settle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rt = 1'b0; ex_mem_read = 1'b0; br_taken = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
  endtask

  initial begin
    clear_in();
    #3;
    check("reset_ctrl", 32'(ctrl), 32'(C_IDLE));
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset_flush_cnt", 32'(flush_cnt), 32'd0);
    check("reset_err", 32'(mem_err), 32'd0);
    mem_req = 1'b1;
    #1 check("reset_req_idle", 32'(ctrl), 32'(C_IDLE));
    mem_req = 1'b0;
    @(negedge clk) rst = 1'b1;

    // Load-use on rs
    cyc(); set_load_use();
    #1 check("ldu_rs_ctrl", 32'(ctrl), 32'(C_LDUSE));
    cyc(); clear_in();
    #1 check("ldu_rs_cnt", 32'(stall_cnt), 32'd1);
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    #1 check("ldu_r0_ctrl", 32'(ctrl), 32'(C_IDLE));
    // Load-use on rt, then same with rt unused
    ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b1;
    #1 check("ldu_rt_ctrl", 32'(ctrl), 32'(C_LDUSE));
    cyc(); id_uses_rt = 1'b0;
    #1 check("ldu_rt_unused", 32'(ctrl), 32'(C_IDLE));
    check("ldu_rt_cnt", 32'(stall_cnt), 32'd2);
    clear_in();

    // Memory access, ack in 3rd MEM_WAIT cycle
    mem_req = 1'b1;
    #1 check("mem_start", 32'(ctrl), 32'(C_MSTART));
    cyc(); mem_req = 1'b0;
    #1 check("mem_wait1", 32'(ctrl), 32'(C_MSTALL));
    cyc();
    check("mem_wait2", 32'(ctrl), 32'(C_MSTALL));
    cyc(); mem_ack = 1'b1;
    #1 check("mem_ack_release", 32'(ctrl), 32'(C_IDLE));
    cyc();
    check("run_ack_ignored", 32'(ctrl), 32'(C_IDLE));
    cyc(); mem_ack = 1'b0;
    #1 check("run_after_ack", 32'(ctrl), 32'(C_IDLE));
    check("mem_stall_cnt", 32'(stall_cnt), 32'd5);
    check("mem_no_err", 32'(mem_err), 32'd0);

    // Back-to-back minimum-length accesses
    mem_req = 1'b1;
    #1 check("b2b_start1", 32'(ctrl), 32'(C_MSTART));
    cyc(); mem_req = 1'b0; mem_ack = 1'b1;
    #1 check("b2b_ack1", 32'(ctrl), 32'(C_IDLE));
    cyc(); mem_req = 1'b1; mem_ack = 1'b0;
    #1 check("b2b_start2", 32'(ctrl), 32'(C_MSTART));
    cyc(); mem_req = 1'b0; mem_ack = 1'b1;
    #1 check("b2b_ack2", 32'(ctrl), 32'(C_IDLE));
    cyc(); clear_in();
    #1 check("b2b_stall_cnt", 32'(stall_cnt), 32'd7);

    // Memory stall, load-use and branch together
    mem_req = 1'b1; br_taken = 1'b1; set_load_use();
    #1 check("simul_mstart", 32'(ctrl), 32'(C_MSTART));
    cyc(); mem_req = 1'b0;
    #1 check("simul_mwait", 32'(ctrl), 32'(C_MSTALL));
    cyc(); mem_ack = 1'b1;
    #1 check("simul_ldu_over_br", 32'(ctrl), 32'(C_LDUSE));
    cyc(); clear_in();
    #1 check("simul_flush_cnt", 32'(flush_cnt), 32'd0);
    check("simul_stall_cnt", 32'(stall_cnt), 32'd10);

    // Taken branch alone
    br_taken = 1'b1;
    #1 check("branch_ctrl", 32'(ctrl), 32'(C_BRANCH));
    cyc(); clear_in();
    #1 check("branch_flush_cnt", 32'(flush_cnt), 32'd1);
    check("branch_stall_cnt", 32'(stall_cnt), 32'd10);

    // Timeout with TIMEOUT=4
    mem_req = 1'b1;
    cyc(); mem_req = 1'b0;
    cyc(); cyc(); cyc();
    check("tmo_w4_ctrl", 32'(ctrl), 32'(C_MSTALL));
    check("tmo_before", 32'(mem_err), 32'd0);
    cyc();
    check("tmo_set", 32'(mem_err), 32'd1);
    check("tmo_still_wait", 32'(ctrl), 32'(C_MSTALL));
    mem_ack = 1'b1;
    cyc(); mem_ack = 1'b0;
    #1 check("tmo_sticky", 32'(mem_err), 32'd1);
    check("tmo_run_idle", 32'(ctrl), 32'(C_IDLE));

    // Reset mid-MEM_WAIT
    mem_req = 1'b1;
    cyc();
    check("rst_pre_wait", 32'(ctrl), 32'(C_MSTALL));
    rst = 1'b0;
    #1 check("rst_mid_ctrl", 32'(ctrl), 32'(C_IDLE));
    check("rst_mid_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_mid_flush_cnt", 32'(flush_cnt), 32'd0);
    check("rst_mid_err", 32'(mem_err), 32'd0);
    mem_req = 1'b0;
    @(negedge clk) rst = 1'b1;
    #1 check("rst_exit_run", 32'(ctrl), 32'(C_IDLE));
    mem_req = 1'b1;
    #1 check("rst_exit_start", 32'(ctrl), 32'(C_MSTART));
    mem_req = 1'b0;

    // Flush counter saturation
    cyc(); br_taken = 1'b1;
    repeat (65535) cyc();
    check("flush_cnt_max", 32'(flush_cnt), 32'hFFFF);
    repeat (3) cyc();
    check("flush_cnt_sat", 32'(flush_cnt), 32'hFFFF);
    check("sat_branch_ctrl", 32'(ctrl), 32'(C_BRANCH));
    clear_in();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. It detects load-use hazards between the ID and EX stages, squashes the wrong-path fetch on taken branches, and sequences the multi-cycle data-memory handshake. It drives the hold and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also keeps saturating stall and flush counters and a sticky memory-timeout flag.

## Interface
Parameters:
- TIMEOUT, 255, number of MEM_WAIT cycles without `mem_ack_i` after which `mem_err_o` sets.
- CNT_W, 16, width of the performance counters.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  asynchronous, active-low reset
- id_rs_addr_i  in  5  rs field of the instruction in ID
- id_rt_addr_i  in  5  rt field of the instruction in ID
- id_uses_rt_i  in  1  instruction in ID reads rt as a source
- ex_mem_read_i  in  1  ID/EX `Memory_read` control bit (load in EX)
- ex_rt_addr_i  in  5  ID/EX `RTaddr` (load destination)
- id_branch_taken_i  in  1  branch in ID resolved taken
- mem_req_i  in  1  instruction in MEM performs a load or store
- mem_ack_i  in  1  data memory completes the access this cycle
- mem_start_o  out  1  one-cycle pulse that starts a data-memory access
- pc_write_o  out  1  PC load enable
- ifid_stall_o  out  1  IF/ID holds its contents
- ifid_flush_o  out  1  IF/ID loads a NOP
- idex_stall_o  out  1  ID/EX holds (drives the `stall_i` input of ID/EX)
- idex_flush_o  out  1  ID/EX loads all-zero control bits (bubble)
- exmem_stall_o  out  1  EX/MEM holds
- memwb_bubble_o  out  1  MEM/WB loads zero RegWrite/MemtoReg
- stall_cnt_o  out  CNT_W  cycles with `pc_write_o`=0, saturating
- flush_cnt_o  out  CNT_W  taken-branch flushes, saturating
- mem_err_o  out  1  sticky timeout flag

## Operation
- FSM states: RUN (encoding 0) and MEM_WAIT (encoding 1).
- RUN with `mem_req_i`=1:
  - `mem_start_o`=1.
  - Next state is MEM_WAIT.
  - This cycle is already a memory stall.
- MEM_WAIT:
  - On `mem_ack_i`=1, the next state is RUN. Stall outputs deassert in the ack cycle, so MEM moves to WB at the end of that cycle.
  - `mem_ack_i` seen in RUN is ignored.
- Memory stall is asserted in (RUN and `mem_req_i`) or (MEM_WAIT and not `mem_ack_i`). While it is asserted:
  - `pc_write_o`=0, `ifid_stall_o`=1, `idex_stall_o`=1, `exmem_stall_o`=1, `memwb_bubble_o`=1.
  - All flushes are 0.
  - Load-use and branch handling are suppressed.
- Load-use is `ex_mem_read_i` and `ex_rt_addr_i`≠0 and (`ex_rt_addr_i`==`id_rs_addr_i` or (`id_uses_rt_i` and `ex_rt_addr_i`==`id_rt_addr_i`)). Without a memory stall, it gives:
  - `pc_write_o`=0, `ifid_stall_o`=1, `idex_flush_o`=1.
  - All other outputs idle.
- Taken branch, with no memory stall and no load-use: `ifid_flush_o`=1, PC advances, and `flush_cnt_o` increments.
- Priority: memory stall > load-use > branch.
- Idle outputs: `pc_write_o`=1, all other control outputs 0.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Timeout counter:
  - Cleared on entry to MEM_WAIT, increments each MEM_WAIT cycle.
  - When it reaches TIMEOUT, `mem_err_o` sets and stays set until reset.
  - The FSM keeps waiting for the ack.

## Timing
- Stall and flush outputs are combinational from the current state and inputs, so they are valid in the same cycle as the hazard.
- State, counters and `mem_err_o` are registered.
- Reset (`rst_i`=0, asynchronous), taking effect immediately, including mid-MEM_WAIT:
  - State goes to RUN; both counters, the timeout counter and `mem_err_o` go to 0.
  - While reset is held, `mem_start_o`=0 and all other control outputs take their idle values: `pc_write_o`=1, the rest 0.
- A load-use stall lasts exactly 1 cycle. The next cycle, the bubble sits in EX and the hazard clears.
- Minimum memory stall is 1 cycle: the request cycle, then an ack in the first MEM_WAIT cycle.
- Back-to-back accesses: after the ack cycle, a new `mem_req_i` in RUN starts a new access on the next cycle, with no idle gap required.
- `stall_cnt_o` counts every cycle with `pc_write_o`=0, covering both the memory and load-use causes.

## Test plan
- **Load-use hazard:**
  - Stimulus: `ex_mem_read_i`=1, `ex_rt_addr_i`=5, `id_rs_addr_i`=5.
  - Required response: that cycle `pc_write_o`=0, `ifid_stall_o`=1, `idex_flush_o`=1; `stall_cnt_o` reads 1 afterward.
  - Repeat with `ex_rt_addr_i`=0: no stall.
- **Memory access with 3-cycle ack:**
  - Stimulus: `mem_req_i`=1 in RUN, `mem_ack_i` asserted in the 3rd MEM_WAIT cycle.
  - Required response: `mem_start_o` pulses once, stalls are held for 3 cycles and released in the ack cycle, and `stall_cnt_o` increases by 3.
- **Simultaneous events:**
  - Stimulus: memory stall, load-use and taken branch all in the same cycle.
  - Required response: only the memory-stall outputs are active and `flush_cnt_o` is unchanged.
  - Then apply load-use plus branch with no memory stall: the load-use response only, no flush.
- **Taken branch:**
  - Stimulus: `id_branch_taken_i`=1 alone.
  - Required response: `ifid_flush_o`=1, `pc_write_o`=1, `flush_cnt_o`+1.
  - Preload the counter to 0xFFFF (CNT_W=16): it stays at 0xFFFF.
- **Timeout:**
  - Stimulus: TIMEOUT=4, no ack.
  - Required response: `mem_err_o` rises after 4 MEM_WAIT cycles and stays 1 after a later ack.
- **Reset mid-MEM_WAIT:**
  - Stimulus: assert `rst_i`=0 mid-MEM_WAIT.
  - Required response: outputs go idle immediately, and counters and `mem_err_o` read 0.
